// File: rtl/amstrad_raster_irq.sv
// Raster interrupt generator for the Amstrad gate array: a periodic HSYNC-count
// source with VSYNC resync, plus a programmable raster-line (PRI) source.
module amstrad_raster_irq #(
  parameter int CNT_W    = 6,
  parameter int PERIOD   = 52,
  parameter int VS_DELAY = 2,
  parameter int LINE_W   = 9
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CE,
  input  logic              crtc_hs,
  input  logic              crtc_vs,
  input  logic              INTack,
  input  logic              WE,
  input  logic [7:0]        D,
  input  logic              pri_en,
  input  logic [LINE_W-1:0] pri_line,
  output logic              INT,
  output logic              INT_SRC,
  output logic [LINE_W-1:0] LINE
);

  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [2:0]        delay, delay_n;
  logic [LINE_W-1:0] line_n, line_inc;
  logic              old_hs, old_vs;
  logic              gen_irq, gen_n, pri_irq, pri_n;
  logic              hs_fall, vs_rise, ga_clr;

  always_comb begin
    hs_fall  = CE & old_hs & ~crtc_hs;
    vs_rise  = CE & ~old_vs & crtc_vs;
    line_inc = (&LINE) ? LINE : LINE + 1'b1;
    ga_clr   = WE & (D ==? 8'b10?1_????);

    cnt_n   = cnt;
    delay_n = delay;
    line_n  = LINE;
    gen_n   = gen_irq;
    pri_n   = pri_irq;

    // Raises first; acknowledge and the GA clear are applied afterwards so they win.
    if (hs_fall) begin
      if (delay != 3'd0) delay_n = delay - 3'd1;
      if (delay == 3'd1) begin
        cnt_n = '0;
        if (cnt[CNT_W-1] && !pri_en) gen_n = 1'b1;
      end else if (cnt == CNT_W'(PERIOD - 1)) begin
        cnt_n = '0;
        gen_n = ~pri_en;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      line_n = line_inc;
      if (pri_en && line_inc == pri_line) pri_n = 1'b1;
    end

    if (vs_rise) begin
      delay_n = 3'(VS_DELAY);
      line_n  = '0;
    end

    if (!pri_en) pri_n = 1'b0;

    if (INTack) begin
      if (pri_irq) begin
        pri_n = 1'b0;
      end else begin
        gen_n            = 1'b0;
        cnt_n[CNT_W-1]   = 1'b0;
      end
    end

    if (ga_clr) begin
      cnt_n = '0;
      gen_n = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt     <= '0;
      delay   <= '0;
      LINE    <= '0;
      gen_irq <= 1'b0;
      pri_irq <= 1'b0;
      INT     <= 1'b0;
      INT_SRC <= 1'b0;
      old_hs  <= 1'b0;
      old_vs  <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      delay   <= delay_n;
      LINE    <= line_n;
      gen_irq <= gen_n;
      pri_irq <= pri_n;
      INT     <= gen_irq | pri_irq;
      INT_SRC <= pri_irq;
      if (CE) begin
        old_hs <= crtc_hs;
        old_vs <= crtc_vs;
      end
    end
  end

endmodule

// File: tb/tb_amstrad_raster_irq.sv
// Directed bench for amstrad_raster_irq: an integer-level frame model checked every
// cycle, plus literal expectations at the scenario milestones.
module tb_amstrad_raster_irq;

  localparam int CNT_W    = 6;
  localparam int PERIOD   = 52;
  localparam int VS_DELAY = 2;
  localparam int LINE_W   = 9;
  localparam int HALF     = 1 << (CNT_W - 1);
  localparam int LMAX     = (1 << LINE_W) - 1;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              CE = 1'b0;
  logic              crtc_hs = 1'b0;
  logic              crtc_vs = 1'b0;
  logic              INTack = 1'b0;
  logic              WE = 1'b0;
  logic [7:0]        D = '0;
  logic              pri_en = 1'b0;
  logic [LINE_W-1:0] pri_line = '0;
  logic              INT, INT_SRC;
  logic [LINE_W-1:0] LINE;

  amstrad_raster_irq #(
    .CNT_W(CNT_W), .PERIOD(PERIOD), .VS_DELAY(VS_DELAY), .LINE_W(LINE_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .crtc_hs(crtc_hs), .crtc_vs(crtc_vs),
    .INTack(INTack), .WE(WE), .D(D), .pri_en(pri_en), .pri_line(pri_line),
    .INT(INT), .INT_SRC(INT_SRC), .LINE(LINE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Frame model: counts kept as plain integers, events applied in priority order.
  int m_cnt = 0, m_delay = 0, m_line = 0;
  bit m_gen = 0, m_pri = 0, m_int = 0, m_src = 0, m_ohs = 0, m_ovs = 0;
  int c, dl, ln;
  bit g, p, hf, vr;

  always @(posedge CLK) begin
    if (RESET) begin
      m_cnt = 0; m_delay = 0; m_line = 0;
      m_gen = 0; m_pri = 0; m_int = 0; m_src = 0; m_ohs = 0; m_ovs = 0;
    end else begin
      hf = CE && m_ohs && !crtc_hs;
      vr = CE && !m_ovs && crtc_vs;
      c = m_cnt; dl = m_delay; ln = m_line; g = m_gen; p = m_pri;
      if (hf) begin
        ln = (m_line == LMAX) ? LMAX : m_line + 1;
        if (m_delay == 1) begin
          c = 0;
          if (m_cnt >= HALF && !pri_en) g = 1;
        end else begin
          c = (m_cnt + 1) % PERIOD;
          if (c == 0) g = !pri_en;
        end
        if (m_delay > 0) dl = m_delay - 1;
        if (pri_en && ln == int'(pri_line)) p = 1;
      end
      if (vr) begin
        dl = VS_DELAY;
        ln = 0;
      end
      if (!pri_en) p = 0;
      if (INTack) begin
        if (m_pri) p = 0;
        else begin
          g = 0;
          if (c >= HALF) c = c - HALF;
        end
      end
      if (WE && D[7:6] == 2'b10 && D[4]) begin
        c = 0;
        g = 0;
      end
      m_int = m_gen || m_pri;
      m_src = m_pri;
      if (CE) begin
        m_ohs = crtc_hs;
        m_ovs = crtc_vs;
      end
      m_cnt = c; m_delay = dl; m_line = ln; m_gen = g; m_pri = p;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_INT", int'(INT), int'(m_int));
      chk("model_INT_SRC", int'(INT_SRC), int'(m_src));
      chk("model_LINE", int'(LINE), m_line);
      chk("model_cnt", int'(dut.cnt), m_cnt);
    end
  end

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic ce_period();
    CE = 1'b1; cyc();
    CE = 1'b0; cyc(); cyc(); cyc();
  endtask

  task automatic hs_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      crtc_hs = 1'b1; ce_period(); ce_period();
      crtc_hs = 1'b0; ce_period(); ce_period();
    end
  endtask

  task automatic vs_rise_now();
    crtc_vs = 1'b1; ce_period();
    crtc_vs = 1'b0;
  endtask

  task automatic ack();
    INTack = 1'b1; cyc();
    INTack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc(); cyc(); cyc();
    RESET = 1'b0;
    chk_en = 1'b1;
    chk("reset_INT", int'(INT), 0);
    chk("reset_INT_SRC", int'(INT_SRC), 0);
    chk("reset_LINE", int'(LINE), 0);

    // Free run: interrupt after exactly 52 falls
    hs_pulses(51);
    chk("free_51_INT", int'(INT), 0);
    hs_pulses(1);
    chk("free_52_INT", int'(INT), 1);
    chk("free_52_cnt", int'(dut.cnt), 0);
    hs_pulses(8);
    chk("free_60_LINE", int'(LINE), 60);
    ack();
    chk("ack_1clk_INT", int'(INT), 1);
    cyc();
    chk("ack_2clk_INT", int'(INT), 0);

    // Resync with cnt=40: raise
    hs_pulses(32);
    chk("pre_resync_cnt", int'(dut.cnt), 40);
    vs_rise_now();
    hs_pulses(2);
    chk("resync40_INT", int'(INT), 1);
    chk("resync40_cnt", int'(dut.cnt), 0);
    chk("resync40_LINE", int'(LINE), 2);
    ack(); cyc();
    chk("resync40_ack_INT", int'(INT), 0);

    // Resync with cnt=20: no raise
    hs_pulses(20);
    vs_rise_now();
    hs_pulses(2);
    chk("resync20_INT", int'(INT), 0);
    chk("resync20_cnt", int'(dut.cnt), 0);

    // Ack at cnt=45 clears the guard bit, suppressing the resync interrupt
    hs_pulses(45);
    ack(); cyc();
    chk("ack45_cnt", int'(dut.cnt), 13);
    vs_rise_now();
    hs_pulses(2);
    chk("guard_INT", int'(INT), 0);
    chk("guard_cnt", int'(dut.cnt), 0);

    // GA register clear
    hs_pulses(52);
    chk("we_pre_INT", int'(INT), 1);
    hs_pulses(3);
    WE = 1'b1; D = 8'h8C; cyc();
    WE = 1'b0; cyc();
    chk("we8c_INT", int'(INT), 1);
    chk("we8c_cnt", int'(dut.cnt), 3);
    WE = 1'b1; D = 8'h9C; cyc();
    WE = 1'b0;
    chk("we9c_1clk_INT", int'(INT), 1);
    cyc();
    chk("we9c_2clk_INT", int'(INT), 0);
    chk("we9c_cnt", int'(dut.cnt), 0);

    // Programmable raster line
    pri_en = 1'b1; pri_line = 9'd100;
    vs_rise_now();
    hs_pulses(99);
    chk("pri_99_INT", int'(INT), 0);
    hs_pulses(1);
    chk("pri_100_INT", int'(INT), 1);
    chk("pri_100_SRC", int'(INT_SRC), 1);
    chk("pri_100_LINE", int'(LINE), 100);
    hs_pulses(20);
    ack(); cyc();
    chk("pri_ack_INT", int'(INT), 0);
    chk("pri_ack_SRC", int'(INT_SRC), 0);
    hs_pulses(20);
    chk("pri_noperiodic_INT", int'(INT), 0);

    // PRI raise in the same cycle as the periodic acknowledge
    pri_en = 1'b0;
    hs_pulses(PERIOD - m_cnt);
    chk("sim_gen_INT", int'(INT), 1);
    chk("sim_gen_SRC", int'(INT_SRC), 0);
    pri_en = 1'b1;
    pri_line = LINE_W'(m_line + 1);
    crtc_hs = 1'b1; ce_period(); ce_period();
    crtc_hs = 1'b0; CE = 1'b1; INTack = 1'b1; cyc();
    CE = 1'b0; INTack = 1'b0; cyc(); cyc(); cyc();
    chk("sim_INT", int'(INT), 1);
    chk("sim_SRC", int'(INT_SRC), 1);
    ack(); cyc();
    chk("sim_ack_INT", int'(INT), 0);

    // VSYNC rise coincident with HSYNC fall
    crtc_hs = 1'b1; ce_period(); ce_period();
    crtc_hs = 1'b0; crtc_vs = 1'b1; ce_period();
    crtc_vs = 1'b0; ce_period();
    chk("coinc_LINE", int'(LINE), 0);

    // Reset mid-frame
    pri_line = 9'd2;
    hs_pulses(2);
    chk("mid_INT", int'(INT), 1);
    chk("mid_LINE", int'(LINE), 2);
    RESET = 1'b1; cyc();
    chk("rst_INT", int'(INT), 0);
    chk("rst_SRC", int'(INT_SRC), 0);
    chk("rst_LINE", int'(LINE), 0);
    RESET = 1'b0; cyc();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
